// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared UART definitions: TX state encoding, line levels, default frame shape
package uart_pkg;

    localparam int DEFAULT_DATA_BITS = 8;
    localparam int DEFAULT_STOP_BITS = 1;

    localparam logic START_BIT_VAL = 1'b0;
    localparam logic STOP_BIT_VAL  = 1'b1;
    localparam logic IDLE_LINE     = 1'b1;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ARMED,
        ST_START,
        ST_DATA,
        ST_PARITY,
        ST_STOP
    } uart_tx_state_t;

endpackage

// File: rtl/uart_tx.sv
// rtl/uart_tx.sv - UART transmitter paced by an external baud_tick strobe
// Optional parity bit after the data bits when UART_TX_PARITY_EN is defined.
module uart_tx
    import uart_pkg::*;
#(
    parameter int DATA_BITS = DEFAULT_DATA_BITS,
    parameter int STOP_BITS = DEFAULT_STOP_BITS
`ifdef UART_TX_PARITY_EN
    ,
    parameter bit PARITY_ODD = 1'b0
`endif
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [DATA_BITS-1:0] data_in,
    input  logic                 start_tx,
    input  logic                 baud_tick,
    output logic                 tx_done,
    output logic                 tx_line
);

    localparam int CNT_W = $clog2(DATA_BITS + 1);
    localparam logic [CNT_W-1:0] LAST_DATA = CNT_W'(DATA_BITS - 1);
    localparam logic [CNT_W-1:0] LAST_STOP = CNT_W'(STOP_BITS - 1);

    uart_tx_state_t       state_q;
    logic [DATA_BITS-1:0] shift_q;
    logic [CNT_W-1:0]     cnt_q;
    logic                 tx_line_q;
    logic                 tx_done_q;

`ifdef UART_TX_PARITY_EN
    // Parity is taken from the accepted word because the shifter is consumed during DATA.
    logic parity_q;
    logic parity_d;
    assign parity_d = (^data_in) ^ PARITY_ODD;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            shift_q   <= '0;
            cnt_q     <= '0;
            tx_line_q <= IDLE_LINE;
            tx_done_q <= 1'b0;
`ifdef UART_TX_PARITY_EN
            parity_q  <= 1'b0;
`endif
        end else begin
            tx_done_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    tx_line_q <= IDLE_LINE;
                    if (start_tx) begin
                        shift_q <= data_in;
                        cnt_q   <= '0;
                        state_q <= ST_ARMED;
`ifdef UART_TX_PARITY_EN
                        parity_q <= parity_d;
`endif
                    end
                end
                // Waiting for a tick keeps the start bit a full period regardless of request phase.
                ST_ARMED: begin
                    if (baud_tick) begin
                        tx_line_q <= START_BIT_VAL;
                        state_q   <= ST_START;
                    end
                end
                ST_START: begin
                    if (baud_tick) begin
                        tx_line_q <= shift_q[0];
                        shift_q   <= shift_q >> 1;
                        cnt_q     <= '0;
                        state_q   <= ST_DATA;
                    end
                end
                ST_DATA: begin
                    if (baud_tick) begin
                        if (cnt_q == LAST_DATA) begin
                            cnt_q <= '0;
`ifdef UART_TX_PARITY_EN
                            tx_line_q <= parity_q;
                            state_q   <= ST_PARITY;
`else
                            tx_line_q <= STOP_BIT_VAL;
                            state_q   <= ST_STOP;
`endif
                        end else begin
                            tx_line_q <= shift_q[0];
                            shift_q   <= shift_q >> 1;
                            cnt_q     <= cnt_q + CNT_W'(1);
                        end
                    end
                end
`ifdef UART_TX_PARITY_EN
                ST_PARITY: begin
                    if (baud_tick) begin
                        tx_line_q <= STOP_BIT_VAL;
                        cnt_q     <= '0;
                        state_q   <= ST_STOP;
                    end
                end
`endif
                ST_STOP: begin
                    if (baud_tick) begin
                        if (cnt_q == LAST_STOP) begin
                            tx_done_q <= 1'b1;
                            cnt_q     <= '0;
                            state_q   <= ST_IDLE;
                        end else begin
                            cnt_q <= cnt_q + CNT_W'(1);
                        end
                    end
                end
                default: begin
                    tx_line_q <= IDLE_LINE;
                    state_q   <= ST_IDLE;
                end
            endcase
        end
    end

    assign tx_line = tx_line_q;
    assign tx_done = tx_done_q;

endmodule

// File: tb/tb_uart_tx.sv
// tb/tb_uart_tx.sv - scoreboard bench for uart_tx with a 16-clock baud tick
module tb_uart_tx;
    import uart_pkg::*;

    localparam int TICK = 16;
`ifdef UART_TX_PARITY_EN
    localparam bit PODD = 1'b0;
    localparam int NB = 11;
    localparam logic [NB-1:0] F_A5 = {1'b0, 8'b10100101, 1'b0 ^ PODD, 1'b1};
    localparam logic [NB-1:0] F_5A = {1'b0, 8'b01011010, 1'b0 ^ PODD, 1'b1};
    localparam logic [NB-1:0] F_00 = {1'b0, 8'b00000000, 1'b0 ^ PODD, 1'b1};
    localparam logic [NB-1:0] F_FF = {1'b0, 8'b11111111, 1'b0 ^ PODD, 1'b1};
    localparam logic [NB-1:0] F_07 = {1'b0, 8'b11100000, 1'b1 ^ PODD, 1'b1};
`else
    localparam int NB = 10;
    localparam logic [NB-1:0] F_A5 = {1'b0, 8'b10100101, 1'b1};
    localparam logic [NB-1:0] F_5A = {1'b0, 8'b01011010, 1'b1};
    localparam logic [NB-1:0] F_00 = {1'b0, 8'b00000000, 1'b1};
    localparam logic [NB-1:0] F_FF = {1'b0, 8'b11111111, 1'b1};
    localparam logic [NB-1:0] F_07 = {1'b0, 8'b11100000, 1'b1};
`endif

    logic       clk, rst, start_tx, baud_tick, tx_done, tx_line;
    logic [7:0] data_in;

    int checks = 0;
    int errors = 0;
    int done_count = 0;
    int exp_done = 0;
    int tick_cnt = 0;
    logic [NB-1:0] exp_q[$];

    uart_tx #(
        .DATA_BITS(8),
        .STOP_BITS(1)
`ifdef UART_TX_PARITY_EN
        ,
        .PARITY_ODD(PODD)
`endif
    ) dut (
        .clk(clk),
        .rst(rst),
        .data_in(data_in),
        .start_tx(start_tx),
        .baud_tick(baud_tick),
        .tx_done(tx_done),
        .tx_line(tx_line)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        baud_tick = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            tick_cnt  = (tick_cnt + 1) % TICK;
            baud_tick = (tick_cnt == 0);
        end
    end

    initial begin
        #3000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    // Monitor: every clock of a frame must match the expected bit, so bit lengths are checked too.
    initial begin
        logic [NB-1:0] cur;
        logic prev, bad, got;
        int k;
        bit in_frame;
        prev = 1'b1; in_frame = 0; k = 0; bad = 0; got = 0; cur = '0;
        forever begin
            @(negedge clk);
            if (rst) begin
                in_frame = 0;
                prev = 1'b1;
            end else begin
                if (tx_done === 1'b1) done_count++;
                if (!in_frame) begin
                    if (tx_done === 1'b1) begin
                        checks++; errors++;
                        $display("FAIL spurious_done: tx_done=1 outside a frame, required 0");
                    end
                    if (prev === 1'b1 && tx_line === 1'b0) begin
                        checks++;
                        if (exp_q.size() == 0) begin
                            errors++;
                            $display("FAIL unexpected_frame: start bit seen, required none");
                        end else begin
                            cur = exp_q.pop_front();
                            in_frame = 1; k = 0; bad = 0;
                        end
                    end
                end
                if (in_frame) begin
                    if (k < TICK * NB) begin
                        if (tx_line !== cur[NB-1-k/TICK] || tx_done !== 1'b0) begin
                            if (!bad) got = tx_line;
                            bad = 1;
                        end
                        if (k % TICK == TICK - 1) begin
                            checks++;
                            if (bad) begin
                                errors++;
                                $display("FAIL frame_bit%0d: line=%b required %b for all %0d clks (tx_done must stay 0)",
                                         k / TICK, got, cur[NB-1-k/TICK], TICK);
                            end
                            bad = 0;
                        end
                    end else if (k == TICK * NB) begin
                        checks++;
                        if (tx_done !== 1'b1 || tx_line !== 1'b1) begin
                            errors++;
                            $display("FAIL done_pulse: tx_done=%b tx_line=%b required 1 1", tx_done, tx_line);
                        end
                    end else begin
                        checks++;
                        if (tx_done !== 1'b0) begin
                            errors++;
                            $display("FAIL done_width: tx_done=%b required 0", tx_done);
                        end
                        in_frame = 0;
                    end
                    k++;
                end
                prev = tx_line;
            end
        end
    end

    task automatic cyc();
        @(posedge clk);
        #2;
    endtask

    task automatic send(input logic [7:0] d, input int delta);
        int guard = 0;
        while (((TICK - tick_cnt) % TICK) != delta && guard < 3 * TICK) begin
            cyc();
            guard++;
        end
        start_tx = 1'b1;
        data_in  = d;
        cyc();
        start_tx = 1'b0;
        data_in  = ~d;
    endtask

    task automatic wait_done(input int target);
        for (int i = 0; i < TICK * (NB + 4); i++) begin
            if (done_count >= target) return;
            cyc();
        end
        checks++; errors++;
        $display("FAIL done_timeout: done_count=%0d required %0d", done_count, target);
    endtask

    task automatic check_bit(input string name, input logic act, input logic req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %b required %b", name, act, req);
        end
    endtask

    initial begin
        int guard;
        rst = 1'b1; start_tx = 1'b0; data_in = 8'h00;
        repeat (3) cyc();
        check_bit("reset_line", tx_line, 1'b1);
        check_bit("reset_done", tx_done, 1'b0);
        rst = 1'b0;
        cyc();
        check_bit("idle_state", dut.state_q == ST_IDLE, 1'b1);

        // reset while idle
        #1 rst = 1'b1;
        #1 check_bit("idle_rst_line", tx_line, 1'b1);
        cyc();
        rst = 1'b0;
        cyc();

        // basic frame, request 5 clocks before a tick
        exp_q.push_back(F_A5); exp_done++;
        send(8'hA5, 5);
        wait_done(exp_done);

        // request coincident with a tick
        exp_q.push_back(F_A5); exp_done++;
        send(8'hA5, 0);
        wait_done(exp_done);

        exp_q.push_back(F_07); exp_done++;
        send(8'h07, 3);
        wait_done(exp_done);

        // request while busy is dropped
        exp_q.push_back(F_5A); exp_done++;
        send(8'h5A, 7);
        repeat (40) cyc();
        start_tx = 1'b1; data_in = 8'h3C;
        cyc();
        start_tx = 1'b0;
        wait_done(exp_done);
        repeat (TICK * (NB + 2)) cyc();

        // back-to-back
        exp_q.push_back(F_00); exp_q.push_back(F_FF); exp_done += 2;
        send(8'h00, 2);
        guard = 0;
        while (tx_done !== 1'b1 && guard < TICK * (NB + 4)) begin
            cyc();
            guard++;
        end
        check_bit("b2b_first_done", tx_done, 1'b1);
        cyc();
        start_tx = 1'b1; data_in = 8'hFF;
        cyc();
        start_tx = 1'b0; data_in = 8'h00;
        wait_done(exp_done);
        repeat (4) cyc();

        // reset mid-frame aborts and line returns high at once
        exp_q.push_back(F_FF);
        send(8'hFF, 1);
        repeat (50) cyc();
        check_bit("midframe_busy", tx_line, 1'b1);
        #1 rst = 1'b1;
        #1 check_bit("midframe_rst_line", tx_line, 1'b1);
        check_bit("midframe_rst_done", tx_done, 1'b0);
        repeat (2) cyc();
        rst = 1'b0;
        cyc();
        check_bit("midframe_idle", dut.state_q == ST_IDLE, 1'b1);

        exp_q.push_back(F_A5); exp_done++;
        send(8'hA5, 9);
        wait_done(exp_done);
        repeat (TICK * 2) cyc();

        checks++;
        if (done_count != exp_done) begin
            errors++;
            $display("FAIL done_total: %0d pulses, required %0d", done_count, exp_done);
        end
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL frames_left: %0d frames not seen, required 0", exp_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/uart_tx.md
Name: uart_tx

Overview:
- Transmit half of a UART: serialises one parallel word per request onto an asynchronous serial line.
- Frame order: start bit (0), data bits LSB first, optional parity bit, stop bit(s) (1).
- Bit timing comes from an externally generated `baud_tick`; each pulse is one bit period. No internal baud divider.
- Sits between a host/register interface and the TX pad.

Parameters:
- DATA_BITS, 8, number of data bits per frame; width of `data_in`.
- STOP_BITS, 1, number of stop-bit periods (legal values 1 or 2).

Ports:
- clk  input  1  system clock; all state changes on rising edge.
- rst  input  1  asynchronous, active-high reset.
- data_in  input  DATA_BITS  word to transmit; sampled only on the accepting cycle.
- start_tx  input  1  transmit request; one clk cycle wide is sufficient; level-insensitive beyond acceptance.
- baud_tick  input  1  one-clk-wide bit-period strobe; may be asynchronous in phase to `start_tx`.
- tx_done  output  1  one-cycle pulse when the final stop bit period completes.
- tx_line  output  1  serial output; idles high.

Behaviour:
- Reset (async, immediate):
  - `tx_line` = 1, `tx_done` = 0, state = IDLE, bit counter = 0, shift register = 0.
  - Reset mid-frame aborts the frame; the line returns high at once.
- States: IDLE, ARMED, START, DATA, [PARITY], STOP.
- IDLE:
  - `tx_line` = 1.
  - `start_tx` = 1 on a clk edge: latch `data_in` into the shift register and go to ARMED. `baud_tick` is ignored that cycle.
- ARMED:
  - Line held high until the next `baud_tick`.
  - On that tick: go to START and drive `tx_line` = 0.
  - This guarantees every bit, including the start bit, lasts exactly one full tick period.
- START: on `baud_tick`, drive bit 0 of the shift register, go to DATA, counter = 0.
- DATA:
  - On each `baud_tick`: shift right, increment counter.
  - After DATA_BITS bits have been held, go to PARITY (if enabled) or to STOP, driving `tx_line` = 1.
- STOP:
  - `tx_line` = 1 for STOP_BITS tick periods.
  - On the `baud_tick` that ends the last stop period: pulse `tx_done` = 1 for exactly one clk and go to IDLE.
- `tx_done` is 0 in all other cycles.
- A new `start_tx` is accepted from the cycle after the `tx_done` pulse. Back-to-back frames are separated by the ARMED wait (up to one tick period).
- `start_tx` outside IDLE is ignored; no queueing.
- `data_in` changes after acceptance do not affect the frame in flight.
- `tx_line` is registered (glitch-free), changing only on clk edges coincident with `baud_tick` or reset.
- Frame latency:
  - Start-bit falling edge occurs at the first `baud_tick` after acceptance.
  - `tx_done` occurs (1 + DATA_BITS + parity + STOP_BITS) tick periods later.

Optional Feature:
- Macro UART_TX_PARITY_EN.
- Defined:
  - Adds a PARITY state after DATA that transmits one parity bit for one tick period.
  - Even parity by default; odd when parameter PARITY_ODD = 1 (parameter exists only under the macro).
  - Parity is computed from the latched word.
- Undefined: no parity state; frame goes DATA -> STOP directly; PARITY_ODD is not declared.

Decomposition:
- Shared package `uart_pkg`:
  - State enum typedef `uart_tx_state_t`.
  - Constants START_BIT_VAL = 0, STOP_BIT_VAL = 1, IDLE_LINE = 1.
  - Default DATA_BITS / STOP_BITS, shared with a future `uart_rx`.
- No sub-module: the shifter, counter and FSM stay in one module. The baud generator remains external.

Test Plan:
- Reset: assert `rst` mid-idle and mid-frame -> `tx_line` = 1 and `tx_done` = 0 immediately; FSM in IDLE after release.
- Basic frame: `baud_tick` every 16 clks, `data_in` = 0xA5, 1-clk `start_tx` -> `tx_line` per tick = 0,1,0,1,0,0,1,0,1,1 (start, LSB-first data, stop); one-cycle `tx_done` at end of stop bit.
- Start between ticks: `start_tx` 5 clks before a tick vs. coincident with a tick -> start bit still exactly 16 clks long in both cases; no bit shortened.
- Ignore while busy: pulse `start_tx` with `data_in` = 0x3C during the frame of 0x5A -> only the 0x5A frame is sent; a single `tx_done`.
- Back-to-back: 0x00 then 0xFF, second `start_tx` the cycle after `tx_done` -> both frames correct; line high between frames; two `tx_done` pulses.
- Parity (with UART_TX_PARITY_EN): 0x07, even parity -> 11-bit frame with parity bit = 1; with PARITY_ODD = 1 -> parity bit = 0.
